pcx_req_buffer: RTL and testbench

- Sits directly downstream of the SPARC core wrapper on the PCX request path.
- Captures core PCX requests: destination and atomic flag in the pq cycle, payload in the following pa cycle.
- Buffers captured packets in a small in-order FIFO and presents them to the system-side bridge over a valid/ready interface.
- Returns the per-destination PCX grant to the core once the bridge accepts each packet.

---
 rtl/pcx_req_buffer.sv | 164 ++++++++++++++++
 tb/tb_pcx_req_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcx_req_buffer.sv
// pcx_req_buffer
// Captures SPARC core PCX requests (destination/atomic in pq, payload in pa),
// queues them in an in-order FIFO, presents the head to the system bridge over
// valid/ready and returns a one-cycle per-destination grant for every packet
// the bridge accepts.
module pcx_req_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic           gclk,
    input  logic           reset,
    input  logic [4:0]     spc_pcx_req_pq,
    input  logic           spc_pcx_atom_pq,
    input  logic [123:0]   spc_pcx_data_pa,
    output logic [4:0]     pcx_spc_grant_px,
    output logic           pkt_valid,
    input  logic           pkt_ready,
    output logic [4:0]     pkt_dest,
    output logic           pkt_atom,
    output logic [123:0]   pkt_data,
    output logic [AW:0]    fifo_count,
    output logic           ovf_err,
    output logic           proto_err
);

    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    // pq capture stage: holds destination/atomic until the payload arrives
    logic          pend_v_q,    pend_v_d;
    logic [4:0]    pend_dest_q, pend_dest_d;
    logic          pend_atom_q, pend_atom_d;

    // FIFO storage and bookkeeping
    logic [4:0]    dest_mem_q [DEPTH];
    logic [4:0]    dest_mem_d [DEPTH];
    logic          atom_mem_q [DEPTH];
    logic          atom_mem_d [DEPTH];
    logic [123:0]  data_mem_q [DEPTH];
    logic [123:0]  data_mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [AW:0]   count_q,     count_d;

    // Grant pulse and sticky error flags
    logic [4:0]    grant_q,     grant_d;
    logic          ovf_q,       ovf_d;
    logic          proto_q,     proto_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          do_pop;
    logic          do_push;
    logic          ovf_evt;
    logic          multi_hot;

    // Handshake decode: a push at full is only legal when the head leaves the same cycle
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == COUNT_FULL);
        do_pop     = !fifo_empty && pkt_ready;
        do_push    = pend_v_q && (!fifo_full || do_pop);
        ovf_evt    = pend_v_q && fifo_full && !do_pop;
        // x & (x-1) clears the lowest set bit; anything left means two or more bits
        multi_hot  = |(spc_pcx_req_pq & (spc_pcx_req_pq - 5'd1));
    end

    // Next state of the pq capture stage
    always_comb begin
        pend_v_d    = (spc_pcx_req_pq != 5'd0);
        pend_dest_d = spc_pcx_req_pq;
        pend_atom_d = spc_pcx_atom_pq;
    end

    // FIFO tail write, head advance and occupancy tracking
    always_comb begin
        dest_mem_d = dest_mem_q;
        atom_mem_d = atom_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (do_push) begin
            dest_mem_d[wr_ptr_q] = pend_dest_q;
            atom_mem_d[wr_ptr_q] = pend_atom_q;
            data_mem_d[wr_ptr_q] = spc_pcx_data_pa;
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
        end

        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Grant echoes the popped destination for exactly one cycle; errors are sticky
    always_comb begin
        grant_d = do_pop ? dest_mem_q[rd_ptr_q] : 5'd0;
        ovf_d   = ovf_q   || ovf_evt;
        proto_d = proto_q || multi_hot;
    end

    // Capture stage, pointers, count, grant and error registers
    always_ff @(posedge gclk or posedge reset) begin
        if (reset) begin
            pend_v_q    <= 1'b0;
            pend_dest_q <= 5'd0;
            pend_atom_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            grant_q     <= 5'd0;
            ovf_q       <= 1'b0;
            proto_q     <= 1'b0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_dest_q <= pend_dest_d;
            pend_atom_q <= pend_atom_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            grant_q     <= grant_d;
            ovf_q       <= ovf_d;
            proto_q     <= proto_d;
        end
    end

    // FIFO storage; cleared on reset so the head outputs read zero while empty after reset
    always_ff @(posedge gclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                dest_mem_q[i] <= 5'd0;
                atom_mem_q[i] <= 1'b0;
                data_mem_q[i] <= 124'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                dest_mem_q[i] <= dest_mem_d[i];
                atom_mem_q[i] <= atom_mem_d[i];
                data_mem_q[i] <= data_mem_d[i];
            end
        end
    end

    // Output mapping: head entry is read straight from the registered storage
    always_comb begin
        pcx_spc_grant_px = grant_q;
        pkt_valid        = !fifo_empty;
        pkt_dest         = dest_mem_q[rd_ptr_q];
        pkt_atom         = atom_mem_q[rd_ptr_q];
        pkt_data         = data_mem_q[rd_ptr_q];
        fifo_count       = count_q;
        ovf_err          = ovf_q;
        proto_err        = proto_q;
    end

endmodule

// File: tb/tb_pcx_req_buffer.sv
// Scoreboard bench for pcx_req_buffer: the driver keeps a queue-level model of
// the buffer and pushes every packet it expects to be emitted; a monitor pops
// and compares whenever the bridge handshake fires.
module tb_pcx_req_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          gclk  = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    spc_pcx_req_pq  = 5'd0;
    logic          spc_pcx_atom_pq = 1'b0;
    logic [123:0]  spc_pcx_data_pa = 124'd0;
    logic          pkt_ready       = 1'b0;
    logic [4:0]    pcx_spc_grant_px;
    logic          pkt_valid;
    logic [4:0]    pkt_dest;
    logic          pkt_atom;
    logic [123:0]  pkt_data;
    logic [AW:0]   fifo_count;
    logic          ovf_err;
    logic          proto_err;

    pcx_req_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .gclk             (gclk),
        .reset            (reset),
        .spc_pcx_req_pq   (spc_pcx_req_pq),
        .spc_pcx_atom_pq  (spc_pcx_atom_pq),
        .spc_pcx_data_pa  (spc_pcx_data_pa),
        .pcx_spc_grant_px (pcx_spc_grant_px),
        .pkt_valid        (pkt_valid),
        .pkt_ready        (pkt_ready),
        .pkt_dest         (pkt_dest),
        .pkt_atom         (pkt_atom),
        .pkt_data         (pkt_data),
        .fifo_count       (fifo_count),
        .ovf_err          (ovf_err),
        .proto_err        (proto_err)
    );

    always #5 gclk = ~gclk;

    typedef struct packed {
        logic [4:0]   dest;
        logic         atom;
        logic [123:0] data;
    } pkt_t;

    // Reference model state (values as they should be after the most recent edge)
    pkt_t        exp_q[$];
    int          m_count = 0;
    bit          m_ovf   = 1'b0;
    bit          m_proto = 1'b0;
    bit          m_pend_v = 1'b0;
    logic [4:0]  m_pend_dest = 5'd0;
    logic        m_pend_atom = 1'b0;
    logic [4:0]  exp_grant = 5'd0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [123:0] rd();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[123:0];
    endfunction

    function automatic logic [4:0] onehot();
        logic [4:0] one;
        one = 5'd1;
        return one << $urandom_range(4, 0);
    endfunction

    // One core cycle: drive inputs, predict the coming edge, then wait for it
    task automatic cyc(input logic [4:0] req, input logic atom, input logic [123:0] data,
                       input logic rdy);
        bit pop;
        int nc;
        bit novf;
        bit nproto;
        spc_pcx_req_pq  = req;
        spc_pcx_atom_pq = atom;
        spc_pcx_data_pa = data;
        pkt_ready       = rdy;
        pop    = (m_count > 0) && rdy;
        nc     = pop ? m_count - 1 : m_count;
        novf   = m_ovf;
        nproto = m_proto;
        if (m_pend_v) begin
            if (m_count < DEPTH || pop) begin
                nc++;
                exp_q.push_back({m_pend_dest, m_pend_atom, data});
            end else begin
                novf = 1'b1;
            end
        end
        if ($countones(req) > 1) nproto = 1'b1;
        @(posedge gclk);
        m_count     = nc;
        m_ovf       = novf;
        m_proto     = nproto;
        m_pend_v    = (req != 5'd0);
        m_pend_dest = req;
        m_pend_atom = atom;
        #1;
    endtask

    // Reset discards everything buffered or in flight
    task automatic do_reset(input int cycles);
        reset           = 1'b1;
        spc_pcx_req_pq  = 5'd0;
        spc_pcx_atom_pq = 1'b0;
        pkt_ready       = 1'b0;
        exp_q.delete();
        m_count  = 0;
        m_ovf    = 1'b0;
        m_proto  = 1'b0;
        m_pend_v = 1'b0;
        repeat (cycles) @(posedge gclk);
        #1 reset = 1'b0;
    endtask

    // Monitor: per-cycle status compare plus scoreboard pop on each handshake
    initial begin
        forever begin
            @(negedge gclk);
            chk("grant", 128'(pcx_spc_grant_px), reset ? 128'(0) : 128'(exp_grant));
            chk("count", 128'(fifo_count), 128'(m_count));
            chk("valid", 128'(pkt_valid), 128'(m_count != 0));
            chk("ovf_err", 128'(ovf_err), 128'(m_ovf));
            chk("proto_err", 128'(proto_err), 128'(m_proto));
            exp_grant = 5'd0;
            if (!reset && pkt_valid && pkt_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pkt", 128'(pkt_valid), 128'(0));
                end else begin
                    pkt_t e;
                    e = exp_q.pop_front();
                    chk("pkt_dest", 128'(pkt_dest), 128'(e.dest));
                    chk("pkt_atom", 128'(pkt_atom), 128'(e.atom));
                    chk("pkt_data", 128'(pkt_data), 128'(e.data));
                    exp_grant = e.dest;
                end
            end
        end
    end

    initial begin
        int dens;
        logic [4:0] r;
        logic [4:0] two;
        do_reset(3);

        // single request, ready held high
        cyc(5'b00100, 1'b0, rd(), 1'b1);
        cyc(5'd0, 1'b0, 124'hABC, 1'b1);
        repeat (4) cyc(5'd0, 1'b0, rd(), 1'b1);

        // atomic pair held, then drained
        cyc(5'b00001, 1'b1, rd(), 1'b0);
        cyc(5'b00001, 1'b0, rd(), 1'b0);
        cyc(5'd0, 1'b0, rd(), 1'b0);
        cyc(5'd0, 1'b0, rd(), 1'b0);
        repeat (4) cyc(5'd0, 1'b0, rd(), 1'b1);

        // overflow: five back-to-back into a four-entry FIFO
        for (int i = 0; i < 5; i++) cyc(onehot(), 1'b0, rd(), 1'b0);
        cyc(5'd0, 1'b0, rd(), 1'b0);
        cyc(5'd0, 1'b0, rd(), 1'b0);
        repeat (6) cyc(5'd0, 1'b0, rd(), 1'b1);

        // full with a same-cycle pop
        do_reset(2);
        for (int i = 0; i < 5; i++) cyc(onehot(), 1'b0, rd(), 1'b0);
        cyc(5'd0, 1'b0, rd(), 1'b1);
        cyc(5'd0, 1'b0, rd(), 1'b0);
        repeat (6) cyc(5'd0, 1'b0, rd(), 1'b1);

        // pointer wrap with toggling ready
        for (int i = 0; i < 10; i++) cyc(onehot(), 1'b0, rd(), (i % 2) == 1);
        for (int i = 0; i < 12; i++) cyc(5'd0, 1'b0, rd(), (i % 2) == 0);
        repeat (4) cyc(5'd0, 1'b0, rd(), 1'b1);

        // reset with three buffered and one in the pq stage
        for (int i = 0; i < 4; i++) cyc(onehot(), 1'b0, rd(), 1'b0);
        do_reset(2);
        cyc(5'b01000, 1'b0, rd(), 1'b1);
        repeat (4) cyc(5'd0, 1'b0, rd(), 1'b1);

        // randomized traffic, varying bridge back-pressure, occasional multi-hot
        dens = 50;
        for (int i = 0; i < 900; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(2, 0))
                    0:       dens = 20;
                    1:       dens = 55;
                    default: dens = 90;
                endcase
            end
            r = 5'd0;
            if ($urandom_range(99, 0) < 65) r = onehot();
            if (i > 600 && $urandom_range(99, 0) < 3) begin
                two = 5'b00011;
                r = two << $urandom_range(3, 0);
            end
            cyc(r, 1'($urandom_range(1, 0)), rd(), $urandom_range(99, 0) < dens);
        end
        repeat (10) cyc(5'd0, 1'b0, rd(), 1'b1);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
